// File: rtl/uart_pkg.sv
// Shared types and encodings for the configurable UART transmitter:
// FSM states, frame-format codes and frame-format helper functions.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_e;

  localparam int OVERSAMPLE_DEF = 16;

  localparam logic [1:0] DB_5 = 2'b00;
  localparam logic [1:0] DB_6 = 2'b01;
  localparam logic [1:0] DB_7 = 2'b10;
  localparam logic [1:0] DB_8 = 2'b11;

  localparam logic [1:0] PM_NONE     = 2'b00;
  localparam logic [1:0] PM_EVEN     = 2'b01;
  localparam logic [1:0] PM_ODD      = 2'b10;
  localparam logic [1:0] PM_NONE_ALT = 2'b11;

  function automatic logic [2:0] last_bit_idx(input logic [1:0] dbits);
    case (dbits)
      DB_5:    return 3'd4;
      DB_6:    return 3'd5;
      DB_7:    return 3'd6;
      DB_8:    return 3'd7;
      default: return 3'd7;
    endcase
  endfunction

  function automatic logic parity_on(input logic [1:0] pmode);
    case (pmode)
      PM_EVEN:     return 1'b1;
      PM_ODD:      return 1'b1;
      PM_NONE:     return 1'b0;
      PM_NONE_ALT: return 1'b0;
      default:     return 1'b0;
    endcase
  endfunction

  // Only the bits actually sent contribute; odd parity is the inverse of even.
  function automatic logic parity_bit(input logic [7:0] word, input logic [1:0] dbits,
                                      input logic [1:0] pmode);
    logic [7:0] mask;
    mask = 8'hFF >> (2'd3 - dbits);
    return (^(word & mask)) ^ (pmode == PM_ODD);
  endfunction

endpackage

// File: rtl/uart_fifo.sv
// Small synchronous FIFO for transmit words. dout shows the head entry,
// which is valid whenever empty is low; full/empty are registered flags.
module uart_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             push_ok_s, pop_ok_s;

  // Storage, pointer and occupancy next-state; pointers wrap naturally.
  always_comb begin
    push_ok_s = push && !full_q;
    pop_ok_s  = pop && !empty_q;
    mem_d     = mem_q;
    if (push_ok_s) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_ok_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_ok_s, pop_ok_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    full_d  = (count_d == DEPTH_C);
    empty_d = (count_d == {CW{1'b0}});
  end

  // FIFO state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {WIDTH{1'b0}};
      end
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {CW{1'b0}};
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  assign dout  = mem_q[rd_ptr_q];
  assign full  = full_q;
  assign empty = empty_q;

endmodule

// File: rtl/uart_tx_cfg.sv
// UART transmitter with a word FIFO and per-frame format (5-8 data bits,
// none/even/odd parity, 1/2 stop bits) latched when a word is popped.
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = OVERSAMPLE_DEF,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       s_tick,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic [7:0] tx_data,
  input  logic [1:0] data_bits,
  input  logic [1:0] parity_mode,
  input  logic       stop2,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_next_s;
  logic [2:0]    idx_q, idx_d;
  logic          stop_cnt_q, stop_cnt_d;
  logic [7:0]    word_q, word_d;
  logic [1:0]    dbits_q, dbits_d;
  logic [1:0]    pmode_q, pmode_d;
  logic          stop2_lat_q, stop2_lat_d;
  logic          tx_q, tx_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          pop_s, bit_end_s;
  logic [7:0]    fifo_dout_s;
  logic          fifo_full_s, fifo_empty_s;

  uart_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (tx_valid),
    .din   (tx_data),
    .pop   (pop_s),
    .dout  (fifo_dout_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s)
  );

  // Frame sequencing; a bit period ends on the OVERSAMPLE-th s_tick.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    stop_cnt_d = stop_cnt_q;
    done_d     = 1'b0;
    pop_s      = 1'b0;
    bit_end_s  = s_tick && (cnt_q == CNT_LAST);
    if (!s_tick) begin
      cnt_next_s = cnt_q;
    end else if (cnt_q == CNT_LAST) begin
      cnt_next_s = {CW{1'b0}};
    end else begin
      cnt_next_s = cnt_q + CW'(1);
    end
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty_s) begin
          pop_s   = 1'b1;
          state_d = ST_START;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_START: begin
        if (bit_end_s) begin
          state_d = ST_DATA;
          idx_d   = 3'd0;
        end else begin
          state_d = ST_START;
        end
      end
      ST_DATA: begin
        if (!bit_end_s) begin
          state_d = ST_DATA;
        end else if (idx_q != last_bit_idx(dbits_q)) begin
          idx_d = idx_q + 3'd1;
        end else if (parity_on(pmode_q)) begin
          state_d = ST_PARITY;
        end else begin
          state_d    = ST_STOP;
          stop_cnt_d = 1'b0;
        end
      end
      ST_PARITY: begin
        if (bit_end_s) begin
          state_d    = ST_STOP;
          stop_cnt_d = 1'b0;
        end else begin
          state_d = ST_PARITY;
        end
      end
      ST_STOP: begin
        if (!bit_end_s) begin
          state_d = ST_STOP;
        end else if (stop2_lat_q && !stop_cnt_q) begin
          stop_cnt_d = 1'b1;
        end else if (!fifo_empty_s) begin
          done_d  = 1'b1;
          pop_s   = 1'b1;
          state_d = ST_START;
        end else begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    cnt_d = (state_q == ST_IDLE) ? {CW{1'b0}} : cnt_next_s;
  end

  // Word and frame format are captured only at the pop.
  always_comb begin
    if (pop_s) begin
      word_d      = fifo_dout_s;
      dbits_d     = data_bits;
      pmode_d     = parity_mode;
      stop2_lat_d = stop2;
    end else begin
      word_d      = word_q;
      dbits_d     = dbits_q;
      pmode_d     = pmode_q;
      stop2_lat_d = stop2_lat_q;
    end
  end

  // Line level follows the state being entered so tx moves with the state register.
  always_comb begin
    busy_d = (state_d != ST_IDLE);
    case (state_d)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = word_d[idx_d];
      ST_PARITY: tx_d = parity_bit(word_d, dbits_d, pmode_d);
      default:   tx_d = 1'b1;
    endcase
  end

  // Transmitter state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= {CW{1'b0}};
      idx_q       <= 3'd0;
      stop_cnt_q  <= 1'b0;
      word_q      <= 8'h00;
      dbits_q     <= 2'b00;
      pmode_q     <= 2'b00;
      stop2_lat_q <= 1'b0;
      tx_q        <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      stop_cnt_q  <= stop_cnt_d;
      word_q      <= word_d;
      dbits_q     <= dbits_d;
      pmode_q     <= pmode_d;
      stop2_lat_q <= stop2_lat_d;
      tx_q        <= tx_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign tx       = tx_q;
  assign tx_busy  = busy_q;
  assign tx_done  = done_q;
  assign tx_ready = !fifo_full_s;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Directed bench for uart_tx_cfg: hand-encoded frames sampled on every falling
// clock edge, covering formats, back-to-back FIFO traffic, tick stalls and reset.
module tb_uart_tx_cfg;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       s_tick = 1'b1;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic [1:0] data_bits = 2'b11;
  logic [1:0] parity_mode = 2'b00;
  logic       stop2 = 1'b0;
  logic       tx_ready, tx, tx_busy, tx_done;

  int errors = 0;
  int checks = 0;

  // Frames are stored with frame bit j (start bit = j0) at index j.
  localparam logic [11:0] F_8N1_A5 = 12'b00_1101001010;
  localparam logic [11:0] F_7E1_53 = 12'b00_1010100110;
  localparam logic [11:0] F_7O1_53 = 12'b00_1110100110;
  localparam logic [11:0] F_5O2_1F = 12'b000_110111110;

  always #5 clk = ~clk;

  uart_tx_cfg #(.OVERSAMPLE(16), .FIFO_DEPTH(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .s_tick      (s_tick),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .tx_data     (tx_data),
    .data_bits   (data_bits),
    .parity_mode (parity_mode),
    .stop2       (stop2),
    .tx          (tx),
    .tx_busy     (tx_busy),
    .tx_done     (tx_done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  function automatic logic [11:0] frame_8n1(input logic [7:0] w);
    return {3'b001, w, 1'b0};
  endfunction

  // Check samples [first,last) of a frame at 16 clocks per bit, one sample per clock.
  task automatic watch(input logic [11:0] fr, input int first, input int last, input string tag);
    for (int k = first; k < last; k++) begin
      chk($sformatf("%s tx s%0d", tag, k), {31'd0, tx}, {31'd0, fr[k / 16]});
      chk($sformatf("%s busy s%0d", tag, k), {31'd0, tx_busy}, 32'd1);
      if (k != 0) chk($sformatf("%s done s%0d", tag, k), {31'd0, tx_done}, 32'd0);
      step();
    end
  endtask

  task automatic frame_end(input string tag);
    chk({tag, " done pulse"}, {31'd0, tx_done}, 32'd1);
  endtask

  task automatic idle_end(input string tag);
    chk({tag, " idle tx"}, {31'd0, tx}, 32'd1);
    chk({tag, " idle busy"}, {31'd0, tx_busy}, 32'd0);
    step();
    chk({tag, " done width"}, {31'd0, tx_done}, 32'd0);
    chk({tag, " idle tx2"}, {31'd0, tx}, 32'd1);
  endtask

  task automatic push_one(input logic [7:0] w);
    tx_valid = 1'b1;
    tx_data  = w;
    step();
    tx_valid = 1'b0;
  endtask

  logic [7:0] words [5];

  initial begin
    words[0] = 8'h3C; words[1] = 8'h81; words[2] = 8'h00; words[3] = 8'hFF; words[4] = 8'h5A;

    // Reset state
    step(); step();
    chk("rst tx", {31'd0, tx}, 32'd1);
    chk("rst busy", {31'd0, tx_busy}, 32'd0);
    chk("rst done", {31'd0, tx_done}, 32'd0);
    chk("rst ready", {31'd0, tx_ready}, 32'd1);
    rst_n = 1'b1;
    step();
    chk("idle no frame", {31'd0, tx_busy}, 32'd0);

    // 8N1, 0xA5, with one FIFO latency cycle before the start bit
    data_bits = 2'b11; parity_mode = 2'b00; stop2 = 1'b0;
    push_one(8'hA5);
    chk("8N1 latency tx", {31'd0, tx}, 32'd1);
    chk("8N1 latency busy", {31'd0, tx_busy}, 32'd0);
    step();
    watch(F_8N1_A5, 0, 160, "8N1");
    frame_end("8N1");
    idle_end("8N1");

    // 7E1 0x53, parity mode switched to odd mid-frame with a second word queued
    data_bits = 2'b10; parity_mode = 2'b01;
    push_one(8'h53);
    step();
    watch(F_7E1_53, 0, 20, "7E1");
    parity_mode = 2'b10;
    tx_valid = 1'b1; tx_data = 8'h53;
    watch(F_7E1_53, 20, 21, "7E1");
    tx_valid = 1'b0;
    watch(F_7E1_53, 21, 160, "7E1");
    frame_end("7E1");
    watch(F_7O1_53, 0, 160, "7O1");
    frame_end("7O1");
    idle_end("7O1");

    // 5O2 0x1F with a ten-clock s_tick gap during START; a push lands in the gap
    data_bits = 2'b00; parity_mode = 2'b10; stop2 = 1'b1;
    push_one(8'h1F);
    step();
    watch(F_5O2_1F, 0, 5, "5O2");
    s_tick = 1'b0;
    tx_valid = 1'b1; tx_data = 8'h1F;
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("stall tx c%0d", i), {31'd0, tx}, 32'd0);
      chk($sformatf("stall busy c%0d", i), {31'd0, tx_busy}, 32'd1);
      step();
      tx_valid = 1'b0;
      chk($sformatf("stall ready c%0d", i), {31'd0, tx_ready}, 32'd1);
    end
    s_tick = 1'b1;
    watch(F_5O2_1F, 5, 144, "5O2");
    frame_end("5O2");
    watch(F_5O2_1F, 0, 144, "5O2b");
    frame_end("5O2b");
    idle_end("5O2b");

    // Five words with depth 4: ready drops exactly at four queued; frames back-to-back
    data_bits = 2'b11; parity_mode = 2'b00; stop2 = 1'b0;
    push_one(words[0]);
    step();
    chk("b2b ready s0", {31'd0, tx_ready}, 32'd1);
    for (int i = 1; i < 5; i++) begin
      tx_valid = 1'b1; tx_data = words[i];
      chk($sformatf("b2b push tx s%0d", i - 1), {31'd0, tx}, 32'd0);
      step();
      chk($sformatf("b2b ready q%0d", i), {31'd0, tx_ready}, (i == 4) ? 32'd0 : 32'd1);
    end
    tx_data = 8'hEE;
    step();
    chk("b2b ready full hold", {31'd0, tx_ready}, 32'd0);
    tx_valid = 1'b0;
    watch(frame_8n1(words[0]), 5, 160, "b2b w0");
    frame_end("b2b w0");
    chk("b2b ready after pop", {31'd0, tx_ready}, 32'd1);
    for (int i = 1; i < 5; i++) begin
      watch(frame_8n1(words[i]), 0, 160, $sformatf("b2b w%0d", i));
      frame_end($sformatf("b2b w%0d", i));
    end
    idle_end("b2b");

    // Reset during data bit 3 with another word queued
    push_one(8'hC3);
    step();
    watch(frame_8n1(8'hC3), 0, 40, "rst frm");
    tx_valid = 1'b1; tx_data = 8'h77;
    watch(frame_8n1(8'hC3), 40, 41, "rst frm");
    tx_valid = 1'b0;
    watch(frame_8n1(8'hC3), 41, 72, "rst frm");
    rst_n = 1'b0;
    #1;
    chk("midrst tx", {31'd0, tx}, 32'd1);
    chk("midrst busy", {31'd0, tx_busy}, 32'd0);
    chk("midrst done", {31'd0, tx_done}, 32'd0);
    chk("midrst ready", {31'd0, tx_ready}, 32'd1);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      chk($sformatf("postrst tx c%0d", i), {31'd0, tx}, 32'd1);
      chk($sformatf("postrst busy c%0d", i), {31'd0, tx_busy}, 32'd0);
      chk($sformatf("postrst done c%0d", i), {31'd0, tx_done}, 32'd0);
      step();
    end
    push_one(8'h96);
    chk("postrst latency tx", {31'd0, tx}, 32'd1);
    step();
    watch(frame_8n1(8'h96), 0, 160, "postrst");
    frame_end("postrst");
    idle_end("postrst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_cfg.md
UART_TX_CFG -- requirements
Module: uart_tx_cfg

Interface
REQ-001 Parameter OVERSAMPLE, default 16: s_tick pulses per bit period (>=2).
REQ-002 Parameter FIFO_DEPTH, default 4: transmit FIFO entries (power of two, >=2).
REQ-003 Port clk  input  1  single clock; all logic on rising edge.
REQ-004 Port rst_n  input  1  asynchronous, active-low reset.
REQ-005 Port s_tick  input  1  oversample strobe, one clk wide.
REQ-006 Port tx_valid  input  1  producer offers tx_data.
REQ-007 Port tx_ready  output  1  FIFO can accept; equals !full.
REQ-008 Port tx_data  input  8  payload, LSB transmitted first.
REQ-009 Port data_bits  input  2  00=5, 01=6, 10=7, 11=8 data bits.
REQ-010 Port parity_mode  input  2  00=none, 01=even, 10=odd, 11=none.
REQ-011 Port stop2  input  1  0=one stop bit, 1=two stop bits.
REQ-012 Port tx  output  1  serial line, registered, idle high.
REQ-013 Port tx_busy  output  1  high while state != IDLE.
REQ-014 Port tx_done  output  1  one-clk pulse at end of last stop bit.

Function
REQ-015 Word accepted on any rising edge with tx_valid && tx_ready; no acceptance when full.
REQ-016 FSM states: IDLE, START, DATA, PARITY, STOP.
REQ-017 IDLE with FIFO non-empty: pop head, latch word and data_bits/parity_mode/stop2, enter START on same edge.
REQ-018 Config inputs are sampled only at the pop; changes mid-frame have no effect on the current frame.
REQ-019 tx is registered and reflects the current state: START=0, DATA=current data bit, PARITY=parity bit, STOP/IDLE=1.
REQ-020 Each START, DATA, PARITY and stop bit lasts exactly OVERSAMPLE s_tick pulses; counter advances only on s_tick.
REQ-021 DATA sends bits 0..N-1 of the latched word (N from data_bits); upper bits are ignored.
REQ-022 After the last data bit: PARITY if parity_mode is 01/10, else STOP.
REQ-023 Even parity bit = XOR of the N sent bits; odd parity bit = its inverse.
REQ-024 STOP lasts 1 or 2 bit periods per latched stop2; then tx_done pulses one clk and the FSM enters IDLE.
REQ-025 If the FIFO is non-empty at the edge that leaves STOP, the FSM goes directly to START (back-to-back, no idle bit) with pop and tx_done on the same edge.
REQ-026 Push to an empty FIFO while IDLE: tx falls on the second edge after acceptance (one FIFO latency cycle, no bypass).
REQ-027 Simultaneous push and pop when not full: both take effect; occupancy unchanged.
REQ-028 FIFO pointers wrap modulo FIFO_DEPTH; occupancy counter is $clog2(FIFO_DEPTH)+1 bits wide.
REQ-029 s_tick absent: FSM and bit timing hold; FIFO push still operates.

Reset
REQ-030 Asserting rst_n low immediately forces tx=1, tx_busy=0, tx_done=0, tx_ready=1, state=IDLE, FIFO empty, counters 0.
REQ-031 Reset mid-frame aborts the frame; FIFO contents are discarded; no tx_done is produced.
REQ-032 After release, the first frame starts only after a new word is accepted.

Structure
REQ-033 Package uart_pkg holds the FSM state enum, data_bits and parity_mode encodings, and OVERSAMPLE default.
REQ-034 Sub-module uart_fifo (parametrised synchronous FIFO: push, pop, full, empty, dout) holds the transmit buffer.

Verification
REQ-035 8N1, OVERSAMPLE=16, s_tick every clk, push 0xA5 -> tx 0,1,0,1,0,0,1,0,1,1, each bit 16 clks; one tx_done.
REQ-036 7E1, push 0x53 -> data bits 1,1,0,0,1,0,1, parity 0, stop 1; byte bit 7 never sent.
REQ-037 5O2, push 0x1F -> five 1s, parity 0, stop high 32 s_ticks before tx_done.
REQ-038 Push 5 words with FIFO_DEPTH=4 while busy -> tx_ready low exactly when 4 queued; all frames sent back-to-back, no idle gap.
REQ-039 Assert rst_n low during DATA bit 3 -> tx=1 immediately, FIFO empty, no tx_done; next push transmits normally.
REQ-040 Change parity_mode mid-frame -> current frame keeps latched mode; next frame uses new mode.
